imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 111 +++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction input side and immediate queue output side.
// The master modport is the environment; the slave modport is the immediate generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     in_val;
  logic                     in_rdy;
  logic [31:0]              in_inst;
  logic [2:0]               in_imm_type;
  logic                     out_val;
  logic                     out_rdy;
  logic [XLEN-1:0]          out_imm;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   out_count;

  modport master (
    output in_val, in_inst, in_imm_type, out_rdy,
    input  in_rdy, out_val, out_imm, out_illegal, out_count
  );

  modport slave (
    input  in_val, in_inst, in_imm_type, out_rdy,
    output in_rdy, out_val, out_imm, out_illegal, out_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// TinyRV1 immediate generator feeding a DEPTH-entry FIFO; decode happens on push.
// Define IMM_GEN_PIPE_UTYPE_EN to decode type 4 (U); otherwise type 4 is reserved.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic logic is_illegal(input logic [2:0] t);
`ifdef IMM_GEN_PIPE_UTYPE_EN
    return (t > 3'd4);
`else
    return (t > 3'd3);
`endif
  endfunction

  // Size casts of signed operands sign-extend, so inst[31] fills the upper bits.
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:7] inst,
                                                        input logic [2:0]  t);
    logic signed [XLEN-1:0] imm;
    imm = '0;
    case (t)
      3'd0: imm = XLEN'($signed(inst[31:20]));
      3'd1: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      3'd2: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      3'd3: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
`ifdef IMM_GEN_PIPE_UTYPE_EN
      3'd4: imm = XLEN'($signed({inst[31:12], 12'b0}));
`endif
      default: imm = '0;
    endcase
    return imm;
  endfunction

  ptr_t                   wr_ptr_q, wr_ptr_d;
  ptr_t                   rd_ptr_q, rd_ptr_d;
  cnt_t                   count_q, count_d;
  logic                   rdy_en_q, rdy_en_d;
  logic signed [XLEN-1:0] imm_mem_q [DEPTH];
  logic                   ill_mem_q [DEPTH];
  logic signed [XLEN-1:0] wr_imm_d;
  logic                   wr_ill_d;
  logic                   in_rdy;
  logic                   out_val;
  logic                   push;
  logic                   pop;
  logic                   unused_opcode;

  assign unused_opcode = ^bus.in_inst[6:0];

  // Decode stage: immediate is formed from the input word and captured only on push.
  always_comb begin
    in_rdy   = rdy_en_q && (count_q < cnt_t'(DEPTH));
    out_val  = (count_q != '0);
    push     = bus.in_val && in_rdy;
    pop      = out_val && bus.out_rdy;
    wr_imm_d = decode_imm(bus.in_inst[31:7], bus.in_imm_type);
    wr_ill_d = is_illegal(bus.in_imm_type);
  end

  // in_rdy is held low until the first edge after reset release.
  always_comb begin
    rdy_en_d = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage stage: data only, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= wr_imm_d;
      ill_mem_q[wr_ptr_q] <= wr_ill_d;
    end
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.out_val     = out_val;
  assign bus.out_count   = count_q;
  assign bus.out_imm     = out_val ? imm_mem_q[rd_ptr_q] : '0;
  assign bus.out_illegal = out_val ? ill_mem_q[rd_ptr_q] : 1'b0;
endmodule
